// File: rtl/lane_color_mapper.sv
// lane_color_mapper: two-stage pixel colour pipeline with a writable 8-entry palette and per-lane receptor flash.
// Optional build macro LANE_COLOR_MAPPER_GRADIENT_EN: blue gradient across the screen for default-class pixels.
`default_nettype none

module lane_color_mapper #(
    parameter int NUM_LANES    = 4,
    parameter int FLASH_FRAMES = 8
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 frame_start,
    input  logic                 pix_valid,
    input  logic                 is_ball,
    input  logic [NUM_LANES-1:0] is_note,
    input  logic [NUM_LANES-1:0] is_receptor,
    input  logic                 is_receptor_background,
    input  logic                 is_background,
    input  logic [NUM_LANES-1:0] hit,
    input  logic [9:0]           DrawX,
    input  logic                 pal_we,
    input  logic [2:0]           pal_addr,
    input  logic [23:0]          pal_data,
    output logic [7:0]           VGA_R,
    output logic [7:0]           VGA_G,
    output logic [7:0]           VGA_B,
    output logic                 out_valid,
    output logic [NUM_LANES-1:0] flash_active
);

    localparam int             CW           = $clog2(FLASH_FRAMES + 1);
    localparam logic [CW-1:0]  c_FLASH_LOAD = CW'(FLASH_FRAMES);
    localparam logic [2:0]     c_IDX_BALL   = 3'd0;
    localparam logic [2:0]     c_IDX_NOTE   = 3'd1;
    localparam logic [2:0]     c_IDX_RCV    = 3'd2;
    localparam logic [2:0]     c_IDX_FLASH  = 3'd3;
    localparam logic [2:0]     c_IDX_RBG    = 3'd4;
    localparam logic [2:0]     c_IDX_BG     = 3'd5;
    localparam logic [2:0]     c_IDX_DEF    = 3'd6;

    logic [CW-1:0]        r_cnt [NUM_LANES];
    logic [NUM_LANES-1:0] w_flash;
    logic [23:0]          r_pal [8];
    logic [2:0]           w_cls;
    logic                 w_rcv_flash;
    logic                 w_rcv_found;
    logic [2:0]           r_s1_cls;
    logic                 r_s1_valid;
    logic [23:0]          w_color;
    logic [23:0]          r_rgb;
    logic                 r_out_valid;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    r_cnt[gi] <= '0;
                end else if (hit[gi]) begin
                    r_cnt[gi] <= c_FLASH_LOAD;
                end else if (frame_start && (r_cnt[gi] != '0)) begin
                    r_cnt[gi] <= r_cnt[gi] - CW'(1);
                end
            end
            assign w_flash[gi] = (r_cnt[gi] != '0);
        end
    endgenerate

    assign flash_active = w_flash;

    // Flash state of the lowest-indexed receptor lane under this pixel
    always_comb begin
        w_rcv_flash = 1'b0;
        w_rcv_found = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (is_receptor[i] && !w_rcv_found) begin
                w_rcv_found = 1'b1;
                w_rcv_flash = w_flash[i];
            end
        end
    end

    always_comb begin
        w_cls = c_IDX_DEF;
        if (is_ball)                     w_cls = c_IDX_BALL;
        else if (|is_note)               w_cls = c_IDX_NOTE;
        else if (|is_receptor)           w_cls = w_rcv_flash ? c_IDX_FLASH : c_IDX_RCV;
        else if (is_receptor_background) w_cls = c_IDX_RBG;
        else if (is_background)          w_cls = c_IDX_BG;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pal[0] <= 24'hFFFFFF;
            r_pal[1] <= 24'hFFFFFF;
            r_pal[2] <= 24'h550000;
            r_pal[3] <= 24'hFFFF55;
            r_pal[4] <= 24'h555555;
            r_pal[5] <= 24'h000000;
            r_pal[6] <= 24'h054BC1;
            r_pal[7] <= 24'h000000;
        end else if (pal_we) begin
            r_pal[pal_addr] <= pal_data;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_s1_cls   <= c_IDX_DEF;
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_cls   <= w_cls;
            r_s1_valid <= pix_valid;
        end
    end

`ifdef LANE_COLOR_MAPPER_GRADIENT_EN
    logic [6:0] r_s1_col;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_s1_col <= '0;
        else          r_s1_col <= DrawX[9:3];
    end

    always_comb begin
        w_color = r_pal[r_s1_cls];
        if (r_s1_cls == c_IDX_DEF) w_color[7:0] = 8'h7F - {1'b0, r_s1_col};
    end
`else
    logic w_unused_drawx;
    assign w_unused_drawx = ^DrawX;

    always_comb begin
        w_color = r_pal[r_s1_cls];
    end
`endif

    // Palette read uses the pre-edge contents, so a same-cycle write shows up one pixel later
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rgb       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_rgb       <= r_s1_valid ? w_color : 24'h000000;
            r_out_valid <= r_s1_valid;
        end
    end

    assign VGA_R     = r_rgb[23:16];
    assign VGA_G     = r_rgb[15:8];
    assign VGA_B     = r_rgb[7:0];
    assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_lane_color_mapper.sv
// tb_lane_color_mapper: directed and randomized checks of lane_color_mapper against a behavioural model.
`default_nettype none

module tb_lane_color_mapper;

    localparam int NL = 4;
    localparam int FF = 8;
`ifdef LANE_COLOR_MAPPER_GRADIENT_EN
    localparam bit GRAD = 1'b1;
`else
    localparam bit GRAD = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          frame_start = 1'b0;
    logic          pix_valid = 1'b0;
    logic          is_ball = 1'b0;
    logic [NL-1:0] is_note = '0;
    logic [NL-1:0] is_receptor = '0;
    logic          is_receptor_background = 1'b0;
    logic          is_background = 1'b0;
    logic [NL-1:0] hit = '0;
    logic [9:0]    DrawX = '0;
    logic          pal_we = 1'b0;
    logic [2:0]    pal_addr = '0;
    logic [23:0]   pal_data = '0;
    logic [7:0]    VGA_R, VGA_G, VGA_B;
    logic          out_valid;
    logic [NL-1:0] flash_active;

    lane_color_mapper #(.NUM_LANES(NL), .FLASH_FRAMES(FF)) u_dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .pix_valid(pix_valid),
        .is_ball(is_ball), .is_note(is_note), .is_receptor(is_receptor),
        .is_receptor_background(is_receptor_background), .is_background(is_background),
        .hit(hit), .DrawX(DrawX), .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .out_valid(out_valid),
        .flash_active(flash_active)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: palette, per-lane frame counters, and a one-entry delay for stage 1
    logic [23:0] m_pal [8];
    int          m_cnt [NL];
    int          m_s1_cls;
    bit          m_s1_v;
    int          m_s1_x;
    logic [23:0] m_out;
    bit          m_out_v;

    function automatic void m_reset();
        m_pal[0] = 24'hFFFFFF; m_pal[1] = 24'hFFFFFF; m_pal[2] = 24'h550000; m_pal[3] = 24'hFFFF55;
        m_pal[4] = 24'h555555; m_pal[5] = 24'h000000; m_pal[6] = 24'h054BC1; m_pal[7] = 24'h000000;
        for (int i = 0; i < NL; i++) m_cnt[i] = 0;
        m_s1_cls = 6; m_s1_v = 0; m_s1_x = 0;
        m_out = 24'h0; m_out_v = 0;
    endfunction

    function automatic int m_class();
        if (is_ball) return 0;
        if (is_note != 0) return 1;
        for (int i = 0; i < NL; i++)
            if (is_receptor[i]) return (m_cnt[i] > 0) ? 3 : 2;
        if (is_receptor_background) return 4;
        if (is_background) return 5;
        return 6;
    endfunction

    function automatic logic [NL-1:0] m_flash();
        logic [NL-1:0] f;
        for (int i = 0; i < NL; i++) f[i] = (m_cnt[i] > 0);
        return f;
    endfunction

    function automatic void m_step();
        int cls;
        cls = m_class();
        if (!m_s1_v)                  m_out = 24'h0;
        else if (GRAD && m_s1_cls == 6) m_out = {m_pal[6][23:8], 8'(127 - m_s1_x / 8)};
        else                          m_out = m_pal[m_s1_cls];
        m_out_v = m_s1_v;
        if (pal_we) m_pal[pal_addr] = pal_data;
        for (int i = 0; i < NL; i++) begin
            if (hit[i])                          m_cnt[i] = FF;
            else if (frame_start && m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
        end
        m_s1_cls = cls; m_s1_v = pix_valid; m_s1_x = int'(DrawX);
    endfunction

    // Inputs are set at a negedge; advance one clock and compare with the model
    task automatic cyc();
        m_step();
        @(negedge Clk);
        chk("rgb", {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, m_out});
        chk("out_valid", 32'(out_valid), 32'(m_out_v));
        chk("flash_active", 32'(flash_active), 32'(m_flash()));
        hit = '0; frame_start = 1'b0; pal_we = 1'b0;
    endtask

    task automatic pix(input bit v, input bit b, input logic [NL-1:0] n, input logic [NL-1:0] r,
                       input bit rb, input bit bg, input int x);
        pix_valid = v; is_ball = b; is_note = n; is_receptor = r;
        is_receptor_background = rb; is_background = bg; DrawX = 10'(x);
    endtask

    task automatic async_reset();
        #2 Reset_n = 1'b0;
        #1;
        chk("rst_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_flash", 32'(flash_active), 32'h0);
        m_reset();
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    initial begin
        m_reset();
        repeat (2) @(negedge Clk);
        chk("reset_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
        chk("reset_valid", 32'(out_valid), 32'h0);
        chk("reset_flash", 32'(flash_active), 32'h0);
        Reset_n = 1'b1;

        pix(1, 1, '0, '0, 0, 0, 0); cyc(); cyc();
        chk("ball_lat2", {8'h0, VGA_R, VGA_G, VGA_B}, 32'hFFFFFF);
        chk("ball_valid", 32'(out_valid), 32'h1);

        pix(1, 0, 4'b0010, 4'b0001, 0, 0, 0); cyc(); cyc();
        chk("note_over_rcv", {8'h0, VGA_R, VGA_G, VGA_B}, 32'hFFFFFF);
        pix(1, 0, '0, 4'b0100, 0, 0, 0); cyc(); cyc();
        chk("rcv_idle", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h550000);

        hit = 4'b0100; cyc();
        chk("hit_flash", 32'(flash_active), 32'h4);
        cyc(); cyc();
        chk("rcv_flash", {8'h0, VGA_R, VGA_G, VGA_B}, 32'hFFFF55);
        for (int k = 0; k < 7; k++) begin frame_start = 1'b1; cyc(); end
        chk("flash_after7", 32'(flash_active), 32'h4);
        frame_start = 1'b1; cyc();
        chk("flash_after8", 32'(flash_active), 32'h0);
        cyc(); cyc();
        chk("rcv_back_idle", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h550000);
        hit = 4'b0100; cyc();
        repeat (7) begin frame_start = 1'b1; cyc(); end
        hit = 4'b0100; frame_start = 1'b1; cyc();
        repeat (7) begin frame_start = 1'b1; cyc(); end
        chk("retrig_alive", 32'(flash_active), 32'h4);
        frame_start = 1'b1; cyc();
        chk("retrig_done", 32'(flash_active), 32'h0);

        pix(1, 0, '0, '0, 0, 1, 0); cyc(); cyc();
        pal_we = 1'b1; pal_addr = 3'd5; pal_data = 24'h123456; cyc();
        chk("pal_old", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h000000);
        cyc();
        chk("pal_new", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h123456);

        pix(0, 1, '0, '0, 0, 0, 0); cyc(); cyc();
        chk("invalid_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
        chk("invalid_valid", 32'(out_valid), 32'h0);

        pix(1, 0, '0, '0, 0, 0, 80); cyc(); cyc();
        chk("default_px", {8'h0, VGA_R, VGA_G, VGA_B}, GRAD ? 32'h054B75 : 32'h054BC1);

        hit = 4'b1111; pix(1, 1, '0, '0, 0, 0, 0); cyc();
        async_reset();
        pix(1, 1, '0, '0, 0, 0, 0); cyc();
        chk("post_rst_lat1", 32'(out_valid), 32'h0);
        cyc();
        chk("post_rst_lat2", {8'h0, VGA_R, VGA_G, VGA_B}, 32'hFFFFFF);

        for (int c = 0; c < 3000; c++) begin
            pix($urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0,
                NL'($urandom_range(0, 3) == 0 ? $urandom : 0),
                NL'($urandom_range(0, 1) == 0 ? $urandom : 0),
                $urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0, $urandom_range(0, 1023));
            hit         = NL'($urandom_range(0, 7) == 0 ? $urandom : 0);
            frame_start = ($urandom_range(0, 3) == 0);
            pal_we      = ($urandom_range(0, 9) == 0);
            pal_addr    = 3'($urandom);
            pal_data    = 24'($urandom);
            cyc();
            if ($urandom_range(0, 299) == 0) async_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, limit %0d", 2000000);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
